// File: rtl/mult_pkg.sv
// Shared definitions for the add-shift multiplier: default operand width and
// the priority-resolved datapath operation seen by the datapath and its controller.
package mult_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [2:0] {
      OP_HOLD,
      OP_CLRLD,
      OP_ADD,
      OP_SUB,
      OP_SHIFT
   } dp_op_e;

   // Clr_Ld beats Sub beats Add beats Shift when several strobes collide.
   function automatic dp_op_e decodeOp(input logic clrLd, input logic add,
                                       input logic sub, input logic shift);
      dp_op_e op;
      op = OP_HOLD;
      if (clrLd)      op = OP_CLRLD;
      else if (sub)   op = OP_SUB;
      else if (add)   op = OP_ADD;
      else if (shift) op = OP_SHIFT;
      return op;
   endfunction

endpackage

// File: rtl/add_sub_nbit.sv
// N-bit ripple-carry adder/subtractor: sum = a + (b ^ {N{sub}}) + sub.
// The final carry-out is never formed because the caller discards it.
module add_sub_nbit #(
   parameter int N = 9
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic [N-1:0] sum
);

   logic [N-1:0] w_bInv;
   logic [N-1:0] w_carry;

   assign w_bInv     = b ^ {N{sub}};
   assign w_carry[0] = sub;

   for (genvar i = 0; i < N; i++) begin : g_fa
      assign sum[i] = a[i] ^ w_bInv[i] ^ w_carry[i];
      if (i < N - 1) begin : g_carry
         assign w_carry[i+1] = (a[i] & w_bInv[i]) | (a[i] & w_carry[i]) |
                               (w_bInv[i] & w_carry[i]);
      end
   end

endmodule

// File: rtl/mult_datapath.sv
// Register/arithmetic datapath of the signed add-shift multiplier: holds X, A, B
// and executes one controller command per clock.
module mult_datapath
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Clr_Ld,
   input  logic             Add,
   input  logic             Sub,
   input  logic             Shift,
   input  logic [WIDTH-1:0] S,
   output logic [WIDTH-1:0] Aval,
   output logic [WIDTH-1:0] Bval,
   output logic             X,
   output logic             M
);

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_x;

   dp_op_e           w_op;
   logic [WIDTH:0]   w_sum;

   assign w_op = decodeOp(Clr_Ld, Add, Sub, Shift);

   // Both operands are sign-extended one bit, so the result cannot overflow.
   add_sub_nbit #(
      .N (WIDTH + 1)
   ) u_addSub (
      .a   ({r_a[WIDTH-1], r_a}),
      .b   ({S[WIDTH-1], S}),
      .sub (w_op == OP_SUB),
      .sum (w_sum)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_a <= '0;
         r_b <= '0;
         r_x <= 1'b0;
      end else begin
         unique case (w_op)
            OP_CLRLD: begin
               r_a <= '0;
               r_x <= 1'b0;
               r_b <= S;
            end
            OP_ADD, OP_SUB: begin
               r_a <= w_sum[WIDTH-1:0];
               r_x <= w_sum[WIDTH];
            end
            OP_SHIFT: begin
               r_a <= {r_x, r_a[WIDTH-1:1]};
               r_b <= {r_a[0], r_b[WIDTH-1:1]};
            end
            default: begin
               r_a <= r_a;
               r_b <= r_b;
               r_x <= r_x;
            end
         endcase
      end
   end

   assign Aval = r_a;
   assign Bval = r_b;
   assign X    = r_x;
   assign M    = r_b[0];

endmodule
